// File: rtl/dcache_port_arbiter.sv
// ----------------------------------------------------------------------------
// dcache_port_arbiter
//
// Shares a single D-cache port between the EX stage and a small replay queue.
// The replay queue holds value-prediction verify loads. At most one D-cache
// request is outstanding at a time. EX normally has priority. A starve counter
// forces a replay grant after STARVE_LIMIT EX grants while replays are waiting.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   ex_valid/write/addr/wdata  EX request; held by EX until ex_ready
//   ex_ready, ex_rdata         EX completion (combinational from dc_resp_valid)
//   rp_push/addr/pc            enqueue a verify load
//   rp_full, rp_overflow       queue full / push dropped (one-cycle pulse)
//   rp_done/done_pc/rdata      verify load completion (combinational)
//   dc_valid/write/addr/wdata  D-cache request, driven from issue registers only
//   dc_resp_valid, dc_rdata    D-cache completion of the current request
//   busy                       arbiter not IDLE
// ----------------------------------------------------------------------------
module dcache_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int QDEPTH       = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  ex_valid,
    input  logic                  ex_write,
    input  logic [ADDR_WIDTH-1:0] ex_addr,
    input  logic [DATA_WIDTH-1:0] ex_wdata,
    output logic                  ex_ready,
    output logic [DATA_WIDTH-1:0] ex_rdata,

    input  logic                  rp_push,
    input  logic [ADDR_WIDTH-1:0] rp_addr,
    input  logic [DATA_WIDTH-1:0] rp_pc,
    output logic                  rp_full,
    output logic                  rp_overflow,
    output logic                  rp_done,
    output logic [DATA_WIDTH-1:0] rp_done_pc,
    output logic [DATA_WIDTH-1:0] rp_rdata,

    output logic                  dc_valid,
    output logic                  dc_write,
    output logic [ADDR_WIDTH-1:0] dc_addr,
    output logic [DATA_WIDTH-1:0] dc_wdata,
    input  logic                  dc_resp_valid,
    input  logic [DATA_WIDTH-1:0] dc_rdata,

    output logic                  busy
);

    localparam int QAW = $clog2(QDEPTH);        // queue index width
    localparam int PW  = QAW + 1;               // pointer width incl. wrap bit
    localparam int SW  = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EX_WAIT = 2'd1,
        RP_WAIT = 2'd2
    } state_t;

    state_t state;

    // ------------------------------------------------------------------
    // Replay queue
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] q_addr [QDEPTH];
    logic [DATA_WIDTH-1:0] q_pc   [QDEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         q_count;
    logic [QAW-1:0]        wr_idx;
    logic [QAW-1:0]        rd_idx;
    logic                  q_empty;
    logic                  push_ok;
    logic                  pop;

    // Pointer difference wraps modulo 2*QDEPTH, so the wrap bit separates
    // full from empty without a separate counter.
    assign q_count = wr_ptr - rd_ptr;
    assign q_empty = (q_count == '0);
    assign rp_full = (q_count == PW'(QDEPTH));
    assign wr_idx  = wr_ptr[QAW-1:0];
    assign rd_idx  = rd_ptr[QAW-1:0];

    // ------------------------------------------------------------------
    // Grant decision (only meaningful in IDLE). Uses registered queue state,
    // so a push into an empty queue becomes eligible one cycle later.
    // ------------------------------------------------------------------
    logic [SW-1:0] starve;
    logic          starve_hit;
    logic          grant_rp;
    logic          grant_ex;

    assign starve_hit = !q_empty && (starve == SW'(STARVE_LIMIT));
    assign grant_rp   = (state == IDLE) && !q_empty && (starve_hit || !ex_valid);
    assign grant_ex   = (state == IDLE) && ex_valid && !starve_hit;

    assign pop = grant_rp;
    // A pop at the same edge frees the slot the push is about to use.
    assign push_ok     = rp_push && (!rp_full || pop);
    assign rp_overflow = rp_push && rp_full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_addr[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else begin
            if (push_ok) begin
                q_addr[wr_idx] <= rp_addr;
                q_pc[wr_idx]   <= rp_pc;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Starve counter: counts EX grants that bypass waiting replays.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve <= '0;
        end else if (q_empty || grant_rp) begin
            starve <= '0;
        end else if (grant_ex && (starve != SW'(STARVE_LIMIT))) begin
            starve <= starve + SW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Port FSM with issue registers. The D-cache sees only these registers,
    // so the request is stable for the whole WAIT state.
    // ------------------------------------------------------------------
    logic                  iss_valid;
    logic                  iss_write;
    logic [ADDR_WIDTH-1:0] iss_addr;
    logic [DATA_WIDTH-1:0] iss_wdata;
    logic [DATA_WIDTH-1:0] iss_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            iss_valid <= 1'b0;
            iss_write <= 1'b0;
            iss_addr  <= '0;
            iss_wdata <= '0;
            iss_pc    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    // dc_resp_valid is ignored here: nothing is outstanding.
                    if (grant_rp) begin
                        state     <= RP_WAIT;
                        iss_valid <= 1'b1;
                        iss_write <= 1'b0;
                        iss_addr  <= q_addr[rd_idx];
                        iss_wdata <= '0;
                        iss_pc    <= q_pc[rd_idx];
                    end else if (grant_ex) begin
                        state     <= EX_WAIT;
                        iss_valid <= 1'b1;
                        iss_write <= ex_write;
                        iss_addr  <= ex_addr;
                        iss_wdata <= ex_wdata;
                        iss_pc    <= '0;
                    end
                end
                EX_WAIT, RP_WAIT: begin
                    if (dc_resp_valid) begin
                        state     <= IDLE;
                        iss_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    iss_valid <= 1'b0;
                end
            endcase
        end
    end

    assign dc_valid = iss_valid;
    assign dc_write = iss_write;
    assign dc_addr  = iss_addr;
    assign dc_wdata = iss_wdata;
    assign busy     = (state != IDLE);

    // Completion is combinational so the requester sees it in the response
    // cycle; data is zeroed outside completion cycles.
    assign ex_ready   = (state == EX_WAIT) && dc_resp_valid;
    assign ex_rdata   = ex_ready ? dc_rdata : '0;
    assign rp_done    = (state == RP_WAIT) && dc_resp_valid;
    assign rp_rdata   = rp_done ? dc_rdata : '0;
    assign rp_done_pc = rp_done ? iss_pc : '0;

endmodule

// File: doc/dcache_port_arbiter.md
DCACHE_PORT_ARBITER -- requirements
Module: dcache_port_arbiter

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 32, data width; ADDR_WIDTH, default 32, address width; QDEPTH, default 2, replay queue depth (power of 2, at least 2); STARVE_LIMIT, default 4, EX grants before replay is forced.
REQ-002 SHALL have one clock; reset is asynchronous and active-low. Ports:
- clk  in  1  clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX stage memory request
- ex_write  in  1  1=store, 0=load
- ex_addr  in  ADDR_WIDTH  EX address
- ex_wdata  in  DATA_WIDTH  store data
- ex_ready  out  1  EX request completes this cycle
- ex_rdata  out  DATA_WIDTH  load data, valid with ex_ready
- rp_push  in  1  enqueue a value-prediction verify load
- rp_addr  in  ADDR_WIDTH  verify address
- rp_pc  in  DATA_WIDTH  PC of the predicted load
- rp_full  out  1  queue full
- rp_overflow  out  1  one-cycle pulse, push dropped
- rp_done  out  1  verify load complete (one-cycle pulse)
- rp_done_pc  out  DATA_WIDTH  PC of the completed verify
- rp_rdata  out  DATA_WIDTH  verify data from memory
- dc_valid  out  1  D-cache request
- dc_write  out  1  D-cache store
- dc_addr  out  ADDR_WIDTH  D-cache address
- dc_wdata  out  DATA_WIDTH  D-cache store data
- dc_resp_valid  in  1  D-cache completes current request
- dc_rdata  in  DATA_WIDTH  D-cache read data
- busy  out  1  state is not IDLE

Function
REQ-003 SHALL keep at most one outstanding D-cache request. FSM states are IDLE, EX_WAIT and RP_WAIT.
REQ-004 In IDLE, SHALL grant as follows:
- replay queue non-empty and starve count at STARVE_LIMIT: grant replay
- else ex_valid: grant EX
- else queue non-empty: grant replay
- else stay IDLE
REQ-005 On grant, SHALL latch the request into issue registers in the same clock edge and enter EX_WAIT or RP_WAIT. dc_valid SHALL be 1 from the next cycle.
REQ-006 dc_valid, dc_write, dc_addr and dc_wdata SHALL come from the issue registers only. They SHALL be stable while in a WAIT state. dc_valid SHALL be 0 in IDLE.
REQ-007 A replay grant SHALL pop the queue head at the grant edge. Replay requests SHALL always be loads (dc_write=0).
REQ-008 In a WAIT state with dc_resp_valid=1:
- EX_WAIT: ex_ready=1 and ex_rdata=dc_rdata, both combinational
- RP_WAIT: rp_done=1, rp_rdata=dc_rdata, rp_done_pc=latched pc
- then return to IDLE on the next edge
Minimum latency is grant edge to response cycle, plus one cycle back to IDLE.
REQ-009 ex_ready SHALL be 0 in every other cycle. EX SHALL hold ex_valid and its fields until ex_ready.
REQ-010 Starve counter:
- clears to 0 on a replay grant or when the queue is empty
- increments, saturating at STARVE_LIMIT, on each EX grant while the queue is non-empty
- counter width is clog2(STARVE_LIMIT+1)
REQ-011 Replay queue:
- circular FIFO; pointers carry an extra wrap bit
- count = wr - rd, modulo 2*QDEPTH
- rp_full = (count == QDEPTH)
REQ-012 rp_push while full and no pop at the same edge SHALL drop the entry and pulse rp_overflow. Push and pop at the same edge while full SHALL both succeed, with count unchanged.
REQ-013 Push into an empty queue SHALL NOT be granted in the same cycle; it is eligible from the next cycle.
REQ-014 dc_resp_valid in IDLE SHALL be ignored.

Reset
REQ-015 While rst_n=0 the block SHALL clear immediately, independent of clk:
- state IDLE
- queue pointers and starve counter 0
- issue registers 0
- all outputs 0
REQ-016 Reset mid-transaction SHALL drop the outstanding request and all queued entries, with no rp_done or ex_ready after release.

Verification
REQ-017 EX load to 0x100, dc_resp_valid 2 cycles after dc_valid with dc_rdata=0xDEAD -> dc_addr=0x100 held stable; ex_ready=1 with ex_rdata=0xDEAD for exactly one cycle; then IDLE.
REQ-018 Push pc=0x40/addr=0x200, no EX traffic -> dc_valid the cycle after next with dc_write=0; on response, rp_done=1 and rp_done_pc=0x40.
REQ-019 Queue holds 1 entry and ex_valid is held high through 5 back-to-back EX stores -> exactly 4 EX grants, then a replay grant, then EX resumes.
REQ-020 QDEPTH=2: three pushes in three cycles with no pop -> rp_full=1 after the second; rp_overflow pulses on the third; count stays 2.
REQ-021 Assert rst_n=0 asynchronously while in RP_WAIT with 1 entry queued -> dc_valid=0 before the next clk edge; after release, busy=0, rp_full=0, no rp_done.
